// File: rtl/mem_responder_pkg.sv
// mem_responder shared definitions: bus width defaults, the no-op fill
// opcode and the two-state sequencer encoding.
// Optional build macro: MEM_WRITE_PROTECT_EN (uses WP_LIMIT_DEFAULT below).
package mem_responder_pkg;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int DATA_W_DEFAULT = 8;

  // Opcode the controller decodes as "do nothing"; a freshly swept memory
  // therefore executes harmlessly if the CPU runs before a program is loaded.
  localparam logic [7:0] NOOP_OPCODE = 8'hFF;

  // First CPU-writable address when write protection is compiled in.
  localparam logic [7:0] WP_LIMIT_DEFAULT = 8'h40;

  // INIT: fill sweep in progress, RUN: serving CPU and loader traffic.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder bus: CPU access port, program-loader handshake and status.
// The master side is the CPU controller (and loader); the slave side is the
// memory responder.
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) ();

  // CPU access
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] to_mem;
  logic              mem_clock;
  logic              mem_write;
  logic [DATA_W-1:0] from_mem;
  logic              mem_ready;

  // Program loader
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;

  // Status
  logic              wp_fault;

  modport master (
    output address, to_mem, mem_clock, mem_write,
    output load_valid, load_addr, load_data,
    input  from_mem, mem_ready, load_ready, wp_fault
  );

  modport slave (
    input  address, to_mem, mem_clock, mem_write,
    input  load_valid, load_addr, load_data,
    output from_mem, mem_ready, load_ready, wp_fault
  );

endinterface

// File: rtl/mem_responder_mem_array.sv
// mem_responder storage: DEPTH x DATA_W single-port array with one
// synchronous write and a registered read. The read register clears on
// reset so the responder presents zero until the first real read.
module mem_responder_mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  // Write port; contents are not reset, the owner sweeps them instead.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read; holds its value whenever no read is requested.
  always_ff @(posedge clk) begin
    if (srst) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: unified 256x8 instruction/data memory answering the CPU
// controller's memory bus, with a secondary program-loader write port.
// After reset the whole array is swept to INIT_VALUE before any access is
// served. Optional build macro MEM_WRITE_PROTECT_EN blocks CPU writes below
// WP_LIMIT and raises a sticky wp_fault; without it wp_fault is tied low.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEFAULT,
  parameter int                DATA_W     = DATA_W_DEFAULT,
  parameter int                DEPTH      = 1 << ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VALUE = DATA_W'(NOOP_OPCODE)
`ifdef MEM_WRITE_PROTECT_EN
  ,
  parameter logic [ADDR_W-1:0] WP_LIMIT   = ADDR_W'(WP_LIMIT_DEFAULT)
`endif
) (
  input logic            clock,
  input logic            reset,
  mem_responder_if.slave bus
);

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] init_ptr_reg;
  logic [ADDR_W-1:0] init_ptr_next;
  logic              mem_ready_reg;

  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              cpu_wr_blocked;
  logic              wp_fault_reg;

`ifdef MEM_WRITE_PROTECT_EN
  // Low addresses hold the boot image; the CPU may not overwrite them.
  assign cpu_wr_blocked = (bus.address < WP_LIMIT);

  // Sticky fault: any suppressed CPU write latches it until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wp_fault_reg <= 1'b0;
    end else if ((state_reg == RUN) && bus.mem_clock && bus.mem_write && cpu_wr_blocked) begin
      wp_fault_reg <= 1'b1;
    end
  end
`else
  assign cpu_wr_blocked = 1'b0;
  assign wp_fault_reg   = 1'b0;
`endif

  // Sequencer state, sweep pointer and the registered ready flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= INIT;
      init_ptr_reg  <= '0;
      mem_ready_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      init_ptr_reg  <= init_ptr_next;
      mem_ready_reg <= (state_next == RUN);
    end
  end

  // Next state and write-source mux: sweep first, then CPU, then loader.
  // Nothing touches the array while reset is high, so a loader request
  // presented during reset is dropped rather than landing early.
  always_comb begin
    state_next    = state_reg;
    init_ptr_next = init_ptr_reg;
    ram_we        = 1'b0;
    ram_re        = 1'b0;
    ram_addr      = bus.address;
    ram_wdata     = bus.to_mem;

    if (!reset) begin
      unique case (state_reg)
        INIT: begin
          ram_we        = 1'b1;
          ram_addr      = init_ptr_reg;
          ram_wdata     = INIT_VALUE;
          init_ptr_next = init_ptr_reg + 1'b1;
          if (init_ptr_reg == ADDR_W'(DEPTH - 1)) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (bus.mem_clock) begin
            if (bus.mem_write) begin
              ram_we = !cpu_wr_blocked;
            end else begin
              ram_re = 1'b1;
            end
          end else if (bus.load_valid) begin
            ram_we    = 1'b1;
            ram_addr  = bus.load_addr;
            ram_wdata = bus.load_data;
          end
        end
        default: begin
          state_next = INIT;
        end
      endcase
    end
  end

  mem_responder_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem_array (
    .clk   (clock),
    .srst  (reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // The loader only gets the port on cycles the CPU leaves idle.
  assign bus.load_ready = !reset && (state_reg == RUN) && !bus.mem_clock;
  assign bus.from_mem   = ram_rdata;
  assign bus.mem_ready  = mem_ready_reg;
  assign bus.wp_fault   = wp_fault_reg;

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Single-port 256x8 unified instruction/data memory that serves the CPU controller's memory interface (address, to_mem, mem_clock, mem_write -> from_mem).
- Adds a secondary program-loader write port with a valid/ready handshake; the bench or boot logic fills program images through it.
- After reset, an init sweep fills the array with a no-op pattern before any access is served.
- Sits beside the controller and is the responder end of its memory bus.

Parameters:
ADDR_W, 8, address width
DATA_W, 8, word width
DEPTH, 256, number of words (2**ADDR_W)
INIT_VALUE, 8'hFF, fill value written during init sweep (NO opcode)
WP_LIMIT, 8'h40, first writable CPU address when write protect is compiled in

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  synchronous, active-high
address  input  ADDR_W  CPU access address
to_mem  input  DATA_W  CPU write data
mem_clock  input  1  CPU access request, level, sampled at posedge clock
mem_write  input  1  1 = write, 0 = read; valid when mem_clock = 1
from_mem  output  DATA_W  registered read data
mem_ready  output  1  high once init sweep completes
load_valid  input  1  loader request
load_ready  output  1  loader may transfer this cycle
load_addr  input  ADDR_W  loader write address
load_data  input  DATA_W  loader write data
wp_fault  output  1  sticky protected-write flag (0 when macro absent)

Behaviour:
- Reset (sync, active-high) values: state=INIT, init_ptr=0, from_mem=0, mem_ready=0, wp_fault=0. load_ready=0 while reset is high.
- FSM has 2 states: INIT and RUN.
- INIT: each cycle writes mem[init_ptr]<=INIT_VALUE and increments init_ptr. When init_ptr==DEPTH-1 it writes the last word and moves to RUN. The sweep takes exactly DEPTH cycles.
- In INIT, mem_clock and load_valid are ignored, from_mem holds 0 and load_ready=0.
- RUN: mem_ready=1, registered.
- CPU read (mem_clock=1, mem_write=0 at posedge N): from_mem<=mem[address]. Data is valid after posedge N. Latency 1 cycle.
- CPU write (mem_clock=1, mem_write=1): mem[address]<=to_mem at that posedge. from_mem holds its previous value.
- With no CPU request, from_mem holds its last value.
- Read of a word written on the previous posedge returns the new data; no bypass is needed because there is one request per cycle.
- load_ready = (state==RUN) && !mem_clock, combinational. The CPU always has priority.
- A loader transfer occurs when load_valid && load_ready at posedge: mem[load_addr]<=load_data.
- A loader held off by mem_clock keeps load_valid/addr/data stable until ready. Nothing is dropped or queued.
- Address wrap: addresses are ADDR_W bits, with no out-of-range case.
- Reset mid-operation (either state): returns to INIT, discards any pending loader transfer, and re-sweeps the full array. Prior contents are lost.

Optional Feature:
MEM_WRITE_PROTECT_EN defined:
- CPU writes with address < WP_LIMIT are suppressed and set wp_fault=1.
- wp_fault stays 1 until reset.
- Loader writes are never protected; reads are unaffected.

MEM_WRITE_PROTECT_EN undefined:
- All CPU writes succeed.
- wp_fault is tied 0.

Decomposition:
Shared package holds:
- ADDR_W/DATA_W defaults
- NOOP_OPCODE (8'hFF) used as INIT_VALUE
- FSM state encoding (INIT=1'b0, RUN=1'b1)

One natural sub-module, mem_array: DEPTH x DATA_W storage with a single synchronous write port and registered read. The top-level mux selects the write source: init sweep, then CPU, then loader.

Test Plan:
1. Release reset, idle -> mem_ready rises exactly 256 cycles after reset deasserts; CPU read 0x37 -> from_mem=0xFF next cycle.
2. Loader load_addr=0x00, load_data=0x12 with mem_clock=0 -> load_ready=1, transfer; CPU read 0x00 -> from_mem=0x12.
3. CPU write 0xA5 to 0x80 while from_mem=0x12 -> from_mem stays 0x12; read 0x80 next cycle -> 0xA5.
4. load_valid=1 (0x10<-0x55) with mem_clock=1 for 3 cycles -> load_ready=0 and mem[0x10]=0xFF throughout; mem_clock drops -> write lands, read 0x10 -> 0x55.
5. Reset asserted when init_ptr=100, and again after writing 0xA5 at 0x80 -> mem_ready=0 for 256 cycles; afterwards reads of 0x64 and 0x80 -> 0xFF.
6. With MEM_WRITE_PROTECT_EN: CPU write 0x77 to 0x3F -> mem[0x3F] unchanged (0xFF), wp_fault=1. Write 0x77 to 0x40 -> succeeds. Loader write to 0x3F -> succeeds.
